// File: rtl/rob_multi_wb_if.sv
// Signal bundle for rob_multi_wb: control, allocate, operand read, writeback,
// broadcast, commit, store and redirect. The ROB is the slave side.
interface rob_multi_wb_if #(
  parameter int DEPTH  = 16,
  parameter int NUM_WB = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = $clog2(DEPTH)
);
  logic                     rdy;
  logic                     flush_in;

  logic                     alloc_valid;
  logic [1:0]               alloc_kind;
  logic [REG_W-1:0]         alloc_rd;
  logic [1:0]               alloc_size;
  logic                     alloc_ready;
  logic [TAG_W-1:0]         alloc_tag;

  logic [TAG_W-1:0]         rd_tag_a;
  logic [TAG_W-1:0]         rd_tag_b;
  logic [DATA_W-1:0]        rd_data_a;
  logic [DATA_W-1:0]        rd_data_b;
  logic                     rd_ok_a;
  logic                     rd_ok_b;

  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB*ADDR_W-1:0] wb_addr;
  logic [NUM_WB-1:0]        wb_redirect;

  logic [NUM_WB-1:0]        bcast_valid;
  logic [NUM_WB*TAG_W-1:0]  bcast_tag;
  logic [NUM_WB*DATA_W-1:0] bcast_data;

  logic                     commit_valid;
  logic [REG_W-1:0]         commit_rd;
  logic [DATA_W-1:0]        commit_data;
  logic [TAG_W-1:0]         commit_tag;

  logic                     st_req;
  logic [ADDR_W-1:0]        st_addr;
  logic [DATA_W-1:0]        st_data;
  logic [1:0]               st_size;
  logic                     st_ack;

  logic                     redirect_valid;
  logic [ADDR_W-1:0]        redirect_pc;
  logic                     flush_out;
  logic [TAG_W:0]           count;

  modport master (
    output rdy, flush_in,
    output alloc_valid, alloc_kind, alloc_rd, alloc_size,
    input  alloc_ready, alloc_tag,
    output rd_tag_a, rd_tag_b,
    input  rd_data_a, rd_data_b, rd_ok_a, rd_ok_b,
    output wb_valid, wb_tag, wb_data, wb_addr, wb_redirect,
    input  bcast_valid, bcast_tag, bcast_data,
    input  commit_valid, commit_rd, commit_data, commit_tag,
    input  st_req, st_addr, st_data, st_size,
    output st_ack,
    input  redirect_valid, redirect_pc, flush_out, count
  );

  modport slave (
    input  rdy, flush_in,
    input  alloc_valid, alloc_kind, alloc_rd, alloc_size,
    output alloc_ready, alloc_tag,
    input  rd_tag_a, rd_tag_b,
    output rd_data_a, rd_data_b, rd_ok_a, rd_ok_b,
    input  wb_valid, wb_tag, wb_data, wb_addr, wb_redirect,
    output bcast_valid, bcast_tag, bcast_data,
    output commit_valid, commit_rd, commit_data, commit_tag,
    output st_req, st_addr, st_data, st_size,
    input  st_ack,
    output redirect_valid, redirect_pc, flush_out, count
  );
endinterface

// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB writeback ports, in-order retire of one entry per
// cycle, store handshake at head and branch/jump redirect with full clear.
module rob_multi_wb #(
  parameter int DEPTH  = 16,
  parameter int NUM_WB = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  rob_multi_wb_if.slave bus
);
  localparam logic [1:0] K_REG    = 2'd0;
  localparam logic [1:0] K_STORE  = 2'd1;
  localparam logic [1:0] K_BRANCH = 2'd2;

  typedef enum logic {IDLE, ST_WAIT} state_t;

  // entry storage
  logic [DEPTH-1:0]             busy, ready, redir;
  logic [DEPTH-1:0][1:0]        kind, size;
  logic [DEPTH-1:0][REG_W-1:0]  rd;
  logic [DEPTH-1:0][DATA_W-1:0] data;
  logic [DEPTH-1:0][ADDR_W-1:0] addr;
  logic [TAG_W-1:0]             head, tail;
  logic [TAG_W:0]               cnt;
  state_t                       state;

  // writeback ports unpacked into lanes
  logic [NUM_WB-1:0][TAG_W-1:0]  w_tag;
  logic [NUM_WB-1:0][DATA_W-1:0] w_data;
  logic [NUM_WB-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_WB-1:0]             wb_hit;

  // registered outputs
  logic [NUM_WB-1:0]             b_valid;
  logic [NUM_WB-1:0][TAG_W-1:0]  b_tag;
  logic [NUM_WB-1:0][DATA_W-1:0] b_data;
  logic                          c_valid;
  logic [REG_W-1:0]              c_rd;
  logic [DATA_W-1:0]             c_data;
  logic [TAG_W-1:0]              c_tag;
  logic                          s_req;
  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_data;
  logic [1:0]                    s_size;
  logic                          r_valid;
  logic [ADDR_W-1:0]             r_pc;
  logic                          f_out;

  logic full, alloc_acc, retire, do_commit, do_redir, st_start;

  assign w_tag  = bus.wb_tag;
  assign w_data = bus.wb_data;
  assign w_addr = bus.wb_addr;

  assign full      = (cnt == (TAG_W+1)'(DEPTH));
  assign alloc_acc = bus.alloc_valid && !full;

  always_comb begin
    for (int i = 0; i < NUM_WB; i++) wb_hit[i] = bus.wb_valid[i] && busy[w_tag[i]];
  end

  // Head decision: only IDLE looks at a ready head; ST_WAIT retires on ack.
  always_comb begin
    retire    = 1'b0;
    do_commit = 1'b0;
    do_redir  = 1'b0;
    st_start  = 1'b0;
    if (state == IDLE) begin
      if (busy[head] && ready[head]) begin
        case (kind[head])
          K_REG:    begin retire = 1'b1; do_commit = 1'b1; end
          K_STORE:  st_start = 1'b1;
          K_BRANCH: begin retire = 1'b1; do_redir = redir[head]; end
          default:  begin retire = 1'b1; do_commit = 1'b1; do_redir = 1'b1; end
        endcase
      end
    end else if (bus.st_ack) begin
      retire = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      ready   <= '0;
      redir   <= '0;
      kind    <= '0;
      size    <= '0;
      rd      <= '0;
      data    <= '0;
      addr    <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      state   <= IDLE;
      b_valid <= '0;
      b_tag   <= '0;
      b_data  <= '0;
      c_valid <= 1'b0;
      c_rd    <= '0;
      c_data  <= '0;
      c_tag   <= '0;
      s_req   <= 1'b0;
      s_addr  <= '0;
      s_data  <= '0;
      s_size  <= '0;
      r_valid <= 1'b0;
      r_pc    <= '0;
      f_out   <= 1'b0;
    end else if (rdy_q()) begin
      c_valid <= 1'b0;
      r_valid <= 1'b0;
      f_out   <= 1'b0;
      b_valid <= '0;
      if (bus.flush_in || do_redir) begin
        // Clear takes precedence over allocs and writebacks this cycle;
        // an external flush also suppresses the head's commit/redirect.
        if (!bus.flush_in) begin
          c_valid <= do_commit;
          c_rd    <= rd[head];
          c_data  <= data[head];
          c_tag   <= head;
          r_valid <= 1'b1;
          f_out   <= 1'b1;
          r_pc    <= addr[head];
        end
        busy  <= '0;
        ready <= '0;
        redir <= '0;
        head  <= '0;
        tail  <= '0;
        cnt   <= '0;
        state <= IDLE;
        s_req <= 1'b0;
      end else begin
        // Ascending port order: the higher index lands last on a shared tag.
        for (int i = 0; i < NUM_WB; i++) begin
          if (wb_hit[i]) begin
            data[w_tag[i]]  <= w_data[i];
            addr[w_tag[i]]  <= w_addr[i];
            redir[w_tag[i]] <= bus.wb_redirect[i];
            ready[w_tag[i]] <= 1'b1;
            b_valid[i]      <= 1'b1;
            b_tag[i]        <= w_tag[i];
            b_data[i]       <= w_data[i];
          end
        end
        if (alloc_acc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          redir[tail] <= 1'b0;
          kind[tail]  <= bus.alloc_kind;
          rd[tail]    <= bus.alloc_rd;
          size[tail]  <= bus.alloc_size;
          tail        <= tail + TAG_W'(1);
        end
        if (retire) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + TAG_W'(1);
        end
        cnt <= cnt + {{TAG_W{1'b0}}, alloc_acc} - {{TAG_W{1'b0}}, retire};
        if (do_commit) begin
          c_valid <= 1'b1;
          c_rd    <= rd[head];
          c_data  <= data[head];
          c_tag   <= head;
        end
        case (state)
          IDLE: if (st_start) begin
            state  <= ST_WAIT;
            s_req  <= 1'b1;
            s_addr <= addr[head];
            s_data <= data[head];
            s_size <= size[head];
          end
          default: if (bus.st_ack) begin
            state <= IDLE;
            s_req <= 1'b0;
          end
        endcase
      end
    end
  end

  function automatic logic rdy_q();
    return bus.rdy;
  endfunction

  assign bus.alloc_ready    = !full;
  assign bus.alloc_tag      = tail;
  assign bus.count          = cnt;
  assign bus.rd_data_a      = data[bus.rd_tag_a];
  assign bus.rd_data_b      = data[bus.rd_tag_b];
  assign bus.rd_ok_a        = busy[bus.rd_tag_a] && ready[bus.rd_tag_a];
  assign bus.rd_ok_b        = busy[bus.rd_tag_b] && ready[bus.rd_tag_b];
  assign bus.bcast_valid    = b_valid;
  assign bus.bcast_tag      = b_tag;
  assign bus.bcast_data     = b_data;
  assign bus.commit_valid   = c_valid;
  assign bus.commit_rd      = c_rd;
  assign bus.commit_data    = c_data;
  assign bus.commit_tag     = c_tag;
  assign bus.st_req         = s_req;
  assign bus.st_addr        = s_addr;
  assign bus.st_data        = s_data;
  assign bus.st_size        = s_size;
  assign bus.redirect_valid = r_valid;
  assign bus.redirect_pc    = r_pc;
  assign bus.flush_out      = f_out;
endmodule

// File: tb/tb_rob_multi_wb.sv
// Scenario bench for rob_multi_wb: commits are checked against a queue of
// expected retirements filled as stimulus is driven.
module tb_rob_multi_wb;
  localparam int DEPTH = 16, NUM_WB = 2, DATA_W = 32, ADDR_W = 32, REG_W = 5, TW = 4;
  localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_multi_wb_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus();
  rob_multi_wb #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [TW-1:0]     tag;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Commit monitor: every commit must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.commit_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected got tag=%0d data=%h want none", bus.commit_tag, bus.commit_data);
      end else begin
        mon_e = sb.pop_front();
        if (bus.commit_tag !== mon_e.tag || bus.commit_rd !== mon_e.rd || bus.commit_data !== mon_e.data) begin
          errors++;
          $display("FAIL commit got tag=%0d rd=%0d data=%h want tag=%0d rd=%0d data=%h",
                   bus.commit_tag, bus.commit_rd, bus.commit_data, mon_e.tag, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] k, input logic [REG_W-1:0] r, input logic [1:0] s);
    bus.alloc_valid = 1'b1;
    bus.alloc_kind  = k;
    bus.alloc_rd    = r;
    bus.alloc_size  = s;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [TW-1:0] t, input logic [31:0] d,
                        input logic [31:0] a, input logic r);
    bus.wb_valid[p]             = 1'b1;
    bus.wb_tag[p*TW +: TW]      = t;
    bus.wb_data[p*DATA_W +: DATA_W] = d;
    bus.wb_addr[p*ADDR_W +: ADDR_W] = a;
    bus.wb_redirect[p]          = r;
  endtask

  task automatic wb1(input int p, input logic [TW-1:0] t, input logic [31:0] d,
                     input logic [31:0] a, input logic r);
    set_wb(p, t, d, a, r);
    tick();
    bus.wb_valid = '0;
  endtask

  task automatic flush();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) tick();
  endtask

  task automatic wait_st_req();
    for (int k = 0; k < 10 && !bus.st_req; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rdy = 1'b1; bus.flush_in = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_kind = '0;
    bus.alloc_rd = '0; bus.alloc_size = '0; bus.rd_tag_a = '0; bus.rd_tag_b = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_data = '0; bus.wb_addr = '0;
    bus.wb_redirect = '0; bus.st_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b want 1", bus.alloc_ready); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL reset_alloc_tag got %0d want 0", bus.alloc_tag); end
    checks++; if ({bus.commit_valid, bus.st_req, bus.redirect_valid, bus.flush_out, bus.bcast_valid, bus.rd_ok_a} !== 7'b0)
      begin errors++; $display("FAIL reset_pulses got %b want 0", {bus.commit_valid, bus.st_req, bus.redirect_valid, bus.flush_out, bus.bcast_valid, bus.rd_ok_a}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.alloc_tag !== TW'(i)) begin errors++; $display("FAIL fill_tag got %0d want %0d", bus.alloc_tag, i); end
      alloc(K_REG, REG_W'(i + 1), 2'd2);
    end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", bus.alloc_ready); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", bus.count); end
    alloc(K_REG, 5'd1, 2'd2);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_drop_count got %0d want 16", bus.count); end
    checks++; if (bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL fill_drop_tag got %0d want 0", bus.alloc_tag); end
    bus.rd_tag_a = 4'd3;
    #1;
    checks++; if (bus.rd_ok_a !== 1'b0) begin errors++; $display("FAIL fill_rd_ok got %b want 0", bus.rd_ok_a); end
    flush();
    checks++; if (bus.count !== 5'd0 || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_flush count=%0d ready=%b want 0/1", bus.count, bus.alloc_ready); end
  endtask

  task automatic test_ooo();
    int ones, rises;
    logic prev;
    for (int i = 0; i < 3; i++) alloc(K_REG, REG_W'(i + 1), 2'd2);
    sb.push_back('{tag: 4'd0, rd: 5'd1, data: 32'h00});
    sb.push_back('{tag: 4'd1, rd: 5'd2, data: 32'h11});
    sb.push_back('{tag: 4'd2, rd: 5'd3, data: 32'h22});
    set_wb(0, 4'd2, 32'h22, 32'h0, 1'b0);
    bus.rd_tag_a = 4'd2;
    #1;
    checks++; if (bus.rd_ok_a !== 1'b0) begin errors++; $display("FAIL ooo_no_bypass got %b want 0", bus.rd_ok_a); end
    tick();
    bus.wb_valid = '0;
    checks++; if (bus.bcast_valid !== 2'b01 || bus.bcast_tag[TW-1:0] !== 4'd2 || bus.bcast_data[31:0] !== 32'h22)
      begin errors++; $display("FAIL ooo_bcast got v=%b tag=%0d data=%h want 01/2/22", bus.bcast_valid, bus.bcast_tag[TW-1:0], bus.bcast_data[31:0]); end
    checks++; if (bus.rd_ok_a !== 1'b1 || bus.rd_data_a !== 32'h22) begin errors++; $display("FAIL ooo_read got ok=%b data=%h want 1/22", bus.rd_ok_a, bus.rd_data_a); end
    wb1(0, 4'd0, 32'h00, 32'h0, 1'b0);
    checks++; if (bus.bcast_valid !== 2'b01) begin errors++; $display("FAIL ooo_bcast_once got %b want 01", bus.bcast_valid); end
    ones = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) set_wb(1, 4'd1, 32'h11, 32'h0, 1'b0);
      tick();
      bus.wb_valid = '0;
      if (bus.commit_valid) ones++;
      if (bus.commit_valid && !prev) rises++;
      prev = bus.commit_valid;
    end
    checks++; if (ones != 3 || rises != 1) begin errors++; $display("FAIL ooo_consecutive got ones=%0d runs=%0d want 3/1", ones, rises); end
    drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ooo_drain pending=%0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_store();
    flush();
    alloc(K_STORE, 5'd0, 2'd0);
    wb1(1, 4'd0, 32'hAB, 32'h1000, 1'b0);
    wait_st_req();
    checks++; if (bus.st_req !== 1'b1) begin errors++; $display("FAIL store_req got %b want 1", bus.st_req); end
    checks++; if (bus.st_addr !== 32'h1000 || bus.st_data !== 32'hAB || bus.st_size !== 2'd0)
      begin errors++; $display("FAIL store_fields got %h/%h/%0d want 1000/ab/0", bus.st_addr, bus.st_data, bus.st_size); end
    tick();
    checks++; if (bus.st_req !== 1'b1 || bus.count !== 5'd1) begin errors++; $display("FAIL store_hold2 req=%b count=%0d want 1/1", bus.st_req, bus.count); end
    tick();
    checks++; if (bus.st_req !== 1'b1 || bus.st_addr !== 32'h1000) begin errors++; $display("FAIL store_hold3 req=%b addr=%h want 1/1000", bus.st_req, bus.st_addr); end
    bus.st_ack = 1'b1;
    tick();
    bus.st_ack = 1'b0;
    checks++; if (bus.st_req !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL store_ack req=%b count=%0d want 0/0", bus.st_req, bus.count); end
  endtask

  task automatic test_mispredict();
    flush();
    alloc(K_BRANCH, 5'd0, 2'd2);
    for (int i = 1; i < 4; i++) alloc(K_REG, REG_W'(i), 2'd2);
    set_wb(0, 4'd1, 32'h1, 32'h0, 1'b0);
    set_wb(1, 4'd2, 32'h2, 32'h0, 1'b0);
    tick();
    set_wb(0, 4'd3, 32'h3, 32'h0, 1'b0);
    set_wb(1, 4'd0, 32'h0, 32'h80, 1'b1);
    tick();
    bus.wb_valid = '0;
    for (int k = 0; k < 10 && !bus.redirect_valid; k++) tick();
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin errors++; $display("FAIL mp_redirect got v=%b pc=%h want 1/80", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.flush_out !== 1'b1 || bus.count !== 5'd0) begin errors++; $display("FAIL mp_flush got f=%b count=%0d want 1/0", bus.flush_out, bus.count); end
    tick();
    checks++; if (bus.redirect_valid !== 1'b0 || bus.flush_out !== 1'b0) begin errors++; $display("FAIL mp_pulse got v=%b f=%b want 0/0", bus.redirect_valid, bus.flush_out); end
    repeat (3) tick();
    bus.rd_tag_a = 4'd1;
    #1;
    checks++; if (bus.rd_ok_a !== 1'b0 || bus.count !== 5'd0 || bus.alloc_tag !== 4'd0)
      begin errors++; $display("FAIL mp_cleared ok=%b count=%0d tag=%0d want 0/0/0", bus.rd_ok_a, bus.count, bus.alloc_tag); end
  endtask

  task automatic test_wrap();
    flush();
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.alloc_tag !== TW'(i % 16)) begin errors++; $display("FAIL wrap_tag got %0d want %0d", bus.alloc_tag, i % 16); end
      sb.push_back('{tag: TW'(i % 16), rd: REG_W'(i + 1), data: 32'(i * 3 + 1)});
      alloc(K_REG, REG_W'(i + 1), 2'd2);
      wb1(i % 2, TW'(i % 16), 32'(i * 3 + 1), 32'h0, 1'b0);
      drain();
    end
    checks++; if (sb.size() != 0 || bus.count !== 5'd0) begin errors++; $display("FAIL wrap_end pending=%0d count=%0d want 0/0", sb.size(), bus.count); sb.delete(); end
  endtask

  task automatic test_collision();
    checks++; if (bus.alloc_tag !== 4'd4) begin errors++; $display("FAIL coll_start_tag got %0d want 4", bus.alloc_tag); end
    alloc(K_REG, 5'd7, 2'd2);
    alloc(K_REG, 5'd8, 2'd2);
    sb.push_back('{tag: 4'd4, rd: 5'd7, data: 32'h44});
    sb.push_back('{tag: 4'd5, rd: 5'd8, data: 32'h2});
    wb1(0, 4'd4, 32'h44, 32'h0, 1'b0);
    set_wb(0, 4'd5, 32'h1, 32'h0, 1'b0);
    set_wb(1, 4'd5, 32'h2, 32'h0, 1'b0);
    tick();
    bus.wb_valid = '0;
    checks++; if (bus.bcast_valid !== 2'b11 || bus.bcast_data !== {32'h2, 32'h1} || bus.bcast_tag !== {4'd5, 4'd5})
      begin errors++; $display("FAIL coll_bcast got v=%b data=%h tag=%h want 11/%h/55", bus.bcast_valid, bus.bcast_data, bus.bcast_tag, {32'h2, 32'h1}); end
    wb1(1, 4'd9, 32'h99, 32'h0, 1'b0);
    checks++; if (bus.bcast_valid !== 2'b00) begin errors++; $display("FAIL coll_idle_wb got %b want 00", bus.bcast_valid); end
    drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL coll_drain pending=%0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_rdy();
    bus.rdy = 1'b0;
    alloc(K_REG, 5'd1, 2'd2);
    checks++; if (bus.count !== 5'd0 || bus.alloc_tag !== 4'd6) begin errors++; $display("FAIL rdy_freeze count=%0d tag=%0d want 0/6", bus.count, bus.alloc_tag); end
    bus.rdy = 1'b1;
  endtask

  task automatic test_abort();
    flush();
    alloc(K_STORE, 5'd0, 2'd1);
    wb1(0, 4'd0, 32'h5, 32'h2000, 1'b0);
    wait_st_req();
    checks++; if (bus.st_req !== 1'b1 || bus.st_size !== 2'd1) begin errors++; $display("FAIL abort_req got %b size=%0d want 1/1", bus.st_req, bus.st_size); end
    flush();
    checks++; if (bus.st_req !== 1'b0 || bus.count !== 5'd0 || bus.redirect_valid !== 1'b0 || bus.flush_out !== 1'b0)
      begin errors++; $display("FAIL abort_flush req=%b count=%0d rv=%b fo=%b want 0/0/0/0", bus.st_req, bus.count, bus.redirect_valid, bus.flush_out); end
    alloc(K_STORE, 5'd0, 2'd2);
    wb1(1, 4'd0, 32'h6, 32'h3000, 1'b0);
    wait_st_req();
    checks++; if (bus.st_req !== 1'b1) begin errors++; $display("FAIL abort_req2 got %b want 1", bus.st_req); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.st_req !== 1'b0 || bus.count !== 5'd0 || bus.alloc_ready !== 1'b1)
      begin errors++; $display("FAIL abort_rst req=%b count=%0d ready=%b want 0/0/1", bus.st_req, bus.count, bus.alloc_ready); end
    tick();
    rst = 1'b0;
    alloc(K_REG, 5'd1, 2'd2);
    checks++; if (bus.count !== 5'd1 || bus.alloc_tag !== 4'd1) begin errors++; $display("FAIL abort_resume count=%0d tag=%0d want 1/1", bus.count, bus.alloc_tag); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo();
    test_store();
    test_mispredict();
    test_wrap();
    test_collision();
    test_rdy();
    test_abort();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_multi_wb.md
ROB_MULTI_WB -- requirements
Module: rob_multi_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of 2, >=4); TAG_W = log2(DEPTH).
REQ-002 SHALL have parameter NUM_WB, default 2, number of writeback ports.
REQ-003 SHALL have parameters DATA_W 32, ADDR_W 32, REG_W 5: data, address and register-index widths.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rdy  in  1  global enable; low freezes all state and registered outputs.
REQ-007 flush_in  in  1  external clear.
REQ-008 alloc_valid in 1; alloc_kind in 2 (0 REG, 1 STORE, 2 BRANCH, 3 JUMP); alloc_rd in REG_W; alloc_size in 2 (0 byte, 1 half, 2 word).
REQ-009 alloc_ready  out  1  high when count < DEPTH; alloc_tag  out  TAG_W  current tail index.
REQ-010 rd_tag_a, rd_tag_b in TAG_W; rd_data_a, rd_data_b out DATA_W; rd_ok_a, rd_ok_b out 1 (entry busy and ready).
REQ-011 wb_valid in NUM_WB; wb_tag in NUM_WB*TAG_W; wb_data in NUM_WB*DATA_W; wb_addr in NUM_WB*ADDR_W (store address or redirect target); wb_redirect in NUM_WB; port i occupies slice i.
REQ-012 bcast_valid out NUM_WB; bcast_tag out NUM_WB*TAG_W; bcast_data out NUM_WB*DATA_W: registered copy of accepted writebacks.
REQ-013 commit_valid out 1; commit_rd out REG_W; commit_data out DATA_W; commit_tag out TAG_W.
REQ-014 st_req out 1; st_addr out ADDR_W; st_data out DATA_W; st_size out 2; st_ack in 1.
REQ-015 redirect_valid out 1; redirect_pc out ADDR_W; flush_out out 1; count out TAG_W+1.

Function
REQ-016 Circular buffer: head, tail wrap DEPTH-1 -> 0; count tracks occupancy; empty when count==0, full when count==DEPTH.
REQ-017 Alloc accepted when alloc_valid && count<DEPTH: entry[tail] busy=1, ready=0, redirect=0; tail+1; alloc when full is dropped, even if a commit occurs the same cycle.
REQ-018 Alloc and retire in the same cycle leave count unchanged.
REQ-019 Writeback port i with wb_valid[i] to a busy entry sets data, addr, redirect flag, ready=1; to a non-busy entry it is ignored and not broadcast.
REQ-020 Two ports hitting the same tag in one cycle: higher port index wins.
REQ-021 bcast_* for port i SHALL be asserted exactly one cycle after an accepted writeback, for one cycle.
REQ-022 Read ports combinational from stored state; no same-cycle bypass from wb inputs.
REQ-023 Commit FSM states IDLE, ST_WAIT; evaluated only in IDLE when entry[head] busy and ready; at most one retire per cycle; minimum wb-to-commit_valid latency 2 cycles.
REQ-024 REG: commit_valid pulse 1 cycle with rd, data, tag; retire head.
REQ-025 STORE: IDLE->ST_WAIT; st_req high with entry addr, data, size, held stable until st_ack; on st_ack retire head, ->IDLE, st_req low next cycle.
REQ-026 BRANCH: retire; if redirect flag set, redirect_valid and flush_out pulse 1 cycle with redirect_pc=addr, and all entries cleared on that edge.
REQ-027 JUMP: commit_valid as REG plus redirect and clear as REQ-026 unconditionally.
REQ-028 Internal clear: head=tail=0, count=0, all busy/ready=0, FSM IDLE; allocs and writebacks in that cycle dropped.
REQ-029 flush_in SHALL perform the internal clear, including abort of ST_WAIT with st_req deasserted; no commit, redirect or flush_out results.
REQ-030 Non-commit pulse outputs (commit_valid, redirect_valid, flush_out, bcast_valid) SHALL be 0 in every cycle not specified above.

Reset
REQ-031 rst SHALL asynchronously force head=tail=0, count=0, all busy/ready/redirect=0, FSM IDLE, all outputs 0 except alloc_ready=1.
REQ-032 rst SHALL override rdy and flush_in; operation resumes on first rising edge after deassertion.

Verification
REQ-033 Fill: 16 REG allocs -> alloc_tag 0..15, alloc_ready=0 and count=16 after 16th; 17th alloc dropped.
REQ-034 Out-of-order wb: tags 2,0,1 with data 0x22,0x00,0x11 -> commit_valid 3 consecutive cycles, tags 0,1,2 in order.
REQ-035 Store: STORE at head, wb addr 0x1000 data 0xAB size 0 -> st_req held 3 cycles until st_ack, retire on ack cycle, count decrements.
REQ-036 Mispredict: tags 0 BRANCH (wb_redirect=1, addr 0x80), 1..3 REG ready -> redirect_valid, redirect_pc=0x80, flush_out one cycle, count=0, no commit for tags 1..3.
REQ-037 Wrap: 20 alloc/commit pairs -> tail wraps 15->0, commit_tag sequence continuous mod 16.
REQ-038 Collision/reset: ports 0,1 write tag 5 with 0x1/0x2 -> committed data 0x2; rst asserted mid ST_WAIT -> st_req low immediately, count=0.
